instr_fetch_unit: RTL and testbench

//  Fetch stage feeding 16-bit instruction words to the decoder (ControlUnit).

---
 rtl/instr_fetch_unit_pkg.sv | 13 +
 rtl/instr_fetch_unit_fetch_buffer.sv | 68 ++++++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word widths, FSM encodings, opcodes.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 16;
  localparam int unsigned INSTR_W        = 16;
  localparam int unsigned BUF_DEPTH_MAX  = 2;

  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Two-entry shift-style FIFO; entry 0 is always the head, so the head holds its last value when empty.
module instr_fetch_unit_fetch_buffer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             pop_eff;

  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    pop_eff = pop_i && (cnt_q != 2'd0);
    if (flush_i) begin
      cnt_d = 2'd0;
    end else if (push_i && pop_eff) begin
      if (cnt_q == 2'd2) begin
        e0_d = e1_q;
        e1_d = data_i;
      end else begin
        e0_d = data_i;
      end
    end else if (push_i) begin
      if (cnt_q == 2'd0) begin
        e0_d  = data_i;
        cnt_d = 2'd1;
      end else if (cnt_q == 2'd1) begin
        e1_d  = data_i;
        cnt_d = 2'd2;
      end
    end else if (pop_eff) begin
      if (cnt_q == 2'd2) e0_d = e1_q;
      cnt_d = cnt_q - 2'd1;
    end
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign head_o  = e0_q;
  assign valid_o = valid_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem reads, buffers words for decode,
// and handles redirect/halt from decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned          ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter int unsigned          BUF_DEPTH = BUF_DEPTH_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_in,
  output logic               halted
);

  localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              drop_q, drop_d;
  logic              halted_q, halted_d;

  logic               buf_push, buf_pop, buf_flush, buf_valid;
  logic [1:0]         buf_count, count_next;
  logic [ENTRY_W-1:0] buf_head;
  logic               acked, redirect_take, halt_take, issue;

  // Next-state: redirect outranks halt, which outranks pushing the acked word.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    req_d      = req_q;
    drop_d     = drop_q;
    buf_push   = 1'b0;
    buf_flush  = 1'b0;
    issue      = 1'b0;

    buf_pop       = buf_valid && instr_ready;
    acked         = req_q && imem_ack;
    redirect_take = (state_q == ST_RUN) && redirect_valid;
    halt_take     = (state_q == ST_RUN) && !redirect_valid && halt_in && buf_valid && instr_ready;

    if (acked) begin
      drop_d = 1'b0;
      if (!drop_q && (state_q == ST_RUN) && !redirect_take && !halt_take) buf_push = 1'b1;
    end

    if (redirect_take) begin
      buf_flush  = 1'b1;
      fetch_pc_d = redirect_pc;
      if (req_q && !imem_ack) drop_d = 1'b1;
    end else if (halt_take) begin
      buf_flush = 1'b1;
      state_d   = ST_HALTED;
    end

    count_next = buf_flush ? 2'd0 : (buf_count + 2'(buf_push) - 2'(buf_pop));

    if ((state_q == ST_RUN) && !redirect_take && !halt_take && (!req_q || imem_ack) &&
        (count_next < 2'(BUF_DEPTH))) begin
      issue = 1'b1;
    end

    // A request is held until acked; no retraction even across a redirect.
    if (!req_q || acked) req_d = issue;
    if (issue) begin
      addr_d     = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end

    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      drop_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      drop_q     <= drop_d;
      halted_q   <= halted_d;
    end
  end

  instr_fetch_unit_fetch_buffer #(
    .WIDTH (ENTRY_W)
  ) u_fetch_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (buf_push),
    .pop_i   (buf_pop),
    .flush_i (buf_flush),
    .data_i  ({addr_q, imem_rdata}),
    .head_o  (buf_head),
    .valid_o (buf_valid),
    .count_o (buf_count)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = buf_valid;
  assign pc_out      = buf_head[ENTRY_W-1 -: ADDR_W];
  assign instr_out   = buf_head[INSTR_W-1:0];
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency instruction memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] pc_out;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halt_in = 1'b0;
  logic        halted;

  int n_chk = 0;
  int n_fail = 0;
  int lat = 1;
  int elapsed;
  logic prev_req, prev_ack;
  logic [15:0] dq_pc[$];
  logic [15:0] dq_in[$];
  logic [15:0] iq[$];

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_in        (halt_in),
    .halted         (halted)
  );

  // Memory contents: word at address a is a ^ 16'h5A5A.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_ack   <= 1'b0;
      imem_rdata <= 16'h0;
      elapsed    <= 0;
    end else if (imem_ack || !imem_req) begin
      imem_ack <= 1'b0;
      elapsed  <= 0;
    end else begin
      elapsed <= elapsed + 1;
      if (elapsed + 1 >= lat) begin
        imem_ack   <= 1'b1;
        imem_rdata <= imem_addr ^ 16'h5A5A;
      end
    end
  end

  // Mid-cycle monitor: accepted words and newly issued request addresses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && instr_ready) begin
        dq_pc.push_back(pc_out);
        dq_in.push_back(instr_out);
      end
      if (imem_req && (!prev_req || prev_ack)) iq.push_back(imem_addr);
      prev_req = imem_req;
      prev_ack = imem_ack;
    end else begin
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    dq_pc.delete();
    dq_in.delete();
    iq.delete();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    halt_in        = 1'b0;
    lat            = 1;
    step();
    step();
    rst_n = 1'b1;
    clear_q();
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k = 0;
    while (dq_pc.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 32'(dq_pc.size() >= n), 32'd1);
  endtask

  initial begin
    int low_run, max_low;
    logic seen_req, any_req, any_valid;

    // 1: reset state, then in-order stream with single-cycle memory
    do_reset();
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr_out, 16'h0000);
    check("rst_pc", pc_out, 16'h0000);
    check("rst_halted", halted, 0);
    instr_ready = 1'b1;
    low_run = 0; max_low = 0; seen_req = 1'b0;
    for (int i = 0; i < 40 && dq_pc.size() < 4; i++) begin
      step();
      if (imem_req) begin
        seen_req = 1'b1;
        low_run = 0;
      end else if (seen_req) begin
        low_run++;
        if (low_run > max_low) max_low = low_run;
      end
    end
    check("t1_count", 32'(dq_pc.size() >= 4), 1);
    if (dq_pc.size() >= 4) begin
      check("t1_pc0", dq_pc[0], 16'h0000);
      check("t1_pc1", dq_pc[1], 16'h0001);
      check("t1_pc2", dq_pc[2], 16'h0002);
      check("t1_pc3", dq_pc[3], 16'h0003);
      check("t1_in0", dq_in[0], 16'h5A5A);
      check("t1_in3", dq_in[3], 16'h5A59);
    end
    check("t1_req_gap", max_low, 0);

    // 2: backpressure fills the buffer and stops requests
    do_reset();
    for (int i = 0; i < 10; i++) step();
    check("t2_req_idle", imem_req, 0);
    check("t2_valid", instr_valid, 1);
    check("t2_head_pc", pc_out, 16'h0000);
    check("t2_head_in", instr_out, 16'h5A5A);
    check("t2_none_taken", dq_pc.size(), 0);
    instr_ready = 1'b1;
    wait_words(3, 30, "t2_timeout");
    if (dq_pc.size() >= 3) begin
      check("t2_pc0", dq_pc[0], 16'h0000);
      check("t2_pc1", dq_pc[1], 16'h0001);
      check("t2_pc2", dq_pc[2], 16'h0002);
      check("t2_in2", dq_in[2], 16'h5A58);
    end

    // 3: redirect while the request for 0x0005 is outstanding
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'h0005); i++) step();
    check("t3_found", 32'(imem_req && imem_addr == 16'h0005), 1);
    lat = 3;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0;
    clear_q();
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_req", imem_req, 1);
      check("t3_hold_addr", imem_addr, 16'h0005);
      if (i < 2) step();
    end
    check("t3_ack", imem_ack, 1);
    step();
    lat = 1;
    check("t3_new_req", imem_req, 1);
    check("t3_new_addr", imem_addr, 16'h0040);
    wait_words(1, 20, "t3_timeout");
    if (dq_pc.size() >= 1) begin
      check("t3_first_pc", dq_pc[0], 16'h0040);
      check("t3_first_in", dq_in[0], 16'h5A1A);
    end

    // 4: redirect in the same cycle as the ack
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 20 && !imem_ack; i++) step();
    check("t4_ack_seen", imem_ack, 1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    clear_q();
    check("t4_idle", imem_req, 0);
    step();
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 16'h0100);
    wait_words(1, 20, "t4_timeout");
    if (dq_pc.size() >= 1) begin
      check("t4_first_pc", dq_pc[0], 16'h0100);
      check("t4_first_in", dq_in[0], 16'h5B5A);
    end

    // 5: halt accepted at pc 0x0003, redirect ignored, reset restarts
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 40 && !(instr_valid && pc_out == 16'h0003); i++) step();
    check("t5_found", 32'(instr_valid && pc_out == 16'h0003), 1);
    halt_in = 1'b1;
    step();
    halt_in = 1'b0;
    check("t5_halted", halted, 1);
    check("t5_valid", instr_valid, 0);
    step();
    any_req = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      redirect_valid = (i == 0);
      redirect_pc = 16'h0020;
      step();
      any_req |= imem_req;
      any_valid |= instr_valid;
    end
    redirect_valid = 1'b0;
    check("t5_no_req", any_req, 0);
    check("t5_no_valid", any_valid, 0);
    check("t5_still_halted", halted, 1);
    rst_n = 1'b0;
    #2;
    check("t5_async_halted", halted, 0);
    check("t5_async_addr", imem_addr, 16'h0000);
    step();
    rst_n = 1'b1;
    step();
    check("t5_restart_req", imem_req, 1);
    check("t5_restart_addr", imem_addr, 16'h0000);

    // 6: PC wrap at 0xFFFF, then redirect wins over a same-cycle halt
    do_reset();
    instr_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect_valid = 1'b0;
    clear_q();
    wait_words(2, 30, "t6_timeout");
    check("t6_issued", 32'(iq.size() >= 2), 1);
    if (iq.size() >= 2) begin
      check("t6_issue0", iq[0], 16'hFFFF);
      check("t6_issue1", iq[1], 16'h0000);
    end
    if (dq_pc.size() >= 2) begin
      check("t6_pc0", dq_pc[0], 16'hFFFF);
      check("t6_in0", dq_in[0], 16'hA5A5);
      check("t6_pc1", dq_pc[1], 16'h0000);
    end
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    check("t6_valid_seen", instr_valid, 1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0010;
    halt_in = 1'b1;
    step();
    redirect_valid = 1'b0;
    halt_in = 1'b0;
    clear_q();
    check("t6_not_halted", halted, 0);
    wait_words(1, 20, "t6_redir_timeout");
    if (dq_pc.size() >= 1) begin
      check("t6_redir_pc", dq_pc[0], 16'h0010);
      check("t6_redir_in", dq_in[0], 16'h5A4A);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
